digit_entry_encoder: RTL and testbench

Keypad-side encoder that collects up to four decimal digit keystrokes and converts them into a 14-bit binary value (0..9999). Its output is the binary bus consumed by the system's 7-segment display decoder. The block holds digits in a BCD shift buffer and supports backspace and clear. On ENTER it runs a 4-cycle multiply-by-10 accumulate and publishes the result with a one-cycle valid pulse.

---
 rtl/digit_entry_encoder.sv | 85 ++++++++
 tb/tb_digit_entry_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/digit_entry_encoder.sv
// digit_entry_encoder: buffers up to four BCD keystrokes and converts them to a 14-bit binary value on ENTER.
module digit_entry_encoder #(
    parameter int NDIG = 4,
    parameter logic [3:0] K_BS = 4'd10,
    parameter logic [3:0] K_CLR = 4'd11,
    parameter logic [3:0] K_ENT = 4'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        ready,
    output logic [13:0] X,
    output logic        X_valid,
    output logic [15:0] bcd,
    output logic [2:0]  digit_count,
    output logic        key_dropped
);
    localparam logic [1:0] S_ENTRY = 2'd0, S_CONV = 2'd1, S_DONE = 2'd2;
    logic [1:0]  state;
    logic [1:0]  step;
    logic [13:0] acc;
    logic [3:0]  nib;
    logic [13:0] acc_next;
    always_comb begin
        nib = step == 2'd0 ? bcd[15:12] : step == 2'd1 ? bcd[11:8] : step == 2'd2 ? bcd[7:4] : bcd[3:0];
        acc_next = (acc << 3) + (acc << 1) + {10'd0, nib};
    end
    assign ready = state == S_ENTRY;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ENTRY;
            step <= 2'd0;
            acc <= 14'd0;
            X <= 14'd0;
            X_valid <= 1'b0;
            bcd <= 16'd0;
            digit_count <= 3'd0;
            key_dropped <= 1'b0;
        end else begin
            X_valid <= 1'b0;
            key_dropped <= 1'b0;
            case (state)
                S_ENTRY: if (key_valid) begin
                    if (key_code < 4'd10) begin
                        if (digit_count < 3'(NDIG)) begin
                            bcd <= {bcd[11:0], key_code};
                            digit_count <= digit_count + 3'd1;
                        end else begin
                            key_dropped <= 1'b1;
                        end
                    end else if (key_code == K_BS) begin
                        if (digit_count != 3'd0) begin
                            bcd <= {4'h0, bcd[15:4]};
                            digit_count <= digit_count - 3'd1;
                        end
                    end else if (key_code == K_CLR) begin
                        bcd <= 16'd0;
                        digit_count <= 3'd0;
                    end else if (key_code == K_ENT) begin
                        state <= S_CONV;
                        step <= 2'd0;
                        acc <= 14'd0;
                    end
                end
                S_CONV: begin
                    key_dropped <= key_valid;
                    acc <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        X <= acc_next;
                        X_valid <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    key_dropped <= key_valid;
                    bcd <= 16'd0;
                    digit_count <= 3'd0;
                    state <= S_ENTRY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digit_entry_encoder.sv
// tb_digit_entry_encoder: directed test-plan sequences plus random keystrokes against a digit-queue reference model.
module tb_digit_entry_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        ready;
    logic [13:0] X;
    logic        X_valid;
    logic [15:0] bcd;
    logic [2:0]  digit_count;
    logic        key_dropped;

    digit_entry_encoder dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .ready(ready), .X(X), .X_valid(X_valid), .bcd(bcd),
        .digit_count(digit_count), .key_dropped(key_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int dq[$];
    int busy = 0;
    int pend = 0;
    int xm = 0;
    bit xv = 0;
    bit kd = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int value_of();
        int v = 0;
        foreach (dq[i]) v = v * 10 + dq[i];
        return v;
    endfunction

    function automatic int bcd_of();
        int b = 0;
        foreach (dq[i]) b = (b << 4) | dq[i];
        return b;
    endfunction

    // busy counts the remaining not-ready cycles after ENTER: 4 conversion + 1 done
    task automatic cyc(input bit r, input bit kv, input int kc);
        rst = r;
        key_valid = kv;
        key_code = 4'(kc);
        @(posedge clk);
        if (r) begin
            dq.delete();
            busy = 0;
            xm = 0;
            xv = 0;
            kd = 0;
        end else begin
            xv = 0;
            kd = 0;
            if (busy > 0) begin
                kd = kv;
                busy--;
                if (busy == 1) begin
                    xm = pend;
                    xv = 1;
                end
                if (busy == 0) dq.delete();
            end else if (kv) begin
                if (kc < 10) begin
                    if (dq.size() < 4) dq.push_back(kc);
                    else kd = 1;
                end else if (kc == 10) begin
                    if (dq.size() > 0) void'(dq.pop_back());
                end else if (kc == 11) begin
                    dq.delete();
                end else if (kc == 12) begin
                    pend = value_of();
                    busy = 5;
                end
            end
        end
        @(negedge clk);
        check("ready", int'(ready), int'(busy == 0));
        check("X", int'(X), xm);
        check("X_valid", int'(X_valid), int'(xv));
        check("bcd", int'(bcd), bcd_of());
        check("digit_count", int'(digit_count), dq.size());
        check("key_dropped", int'(key_dropped), int'(kd));
    endtask

    task automatic keys(input int ks[$]);
        foreach (ks[i]) cyc(0, 1, ks[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        check("rst_X", int'(X), 0);
        check("rst_ready", int'(ready), 1);
        keys('{1, 2, 3, 4});
        check("bcd_1234", int'(bcd), 'h1234);
        cyc(0, 1, 12);
        idle(3);
        check("xv_early", int'(X_valid), 0);
        idle(1);
        check("x_1234", int'(X), 1234);
        check("xv_k4", int'(X_valid), 1);
        idle(1);
        check("ready_after", int'(ready), 1);
        check("bcd_cleared", int'(bcd), 0);
        keys('{9, 9, 9, 9});
        cyc(0, 1, 5);
        check("drop_5th", int'(key_dropped), 1);
        check("bcd_9999", int'(bcd), 'h9999);
        cyc(0, 1, 12);
        idle(5);
        check("x_9999", int'(X), 9999);
        keys('{5, 6});
        check("bcd_56", int'(bcd), 'h56);
        cyc(0, 1, 10);
        check("bcd_bs", int'(bcd), 'h5);
        cyc(0, 1, 7);
        check("bcd_57", int'(bcd), 'h57);
        cyc(0, 1, 12);
        idle(5);
        check("x_57", int'(X), 57);
        cyc(0, 1, 10);
        check("bs_empty_drop", int'(key_dropped), 0);
        check("bs_empty_cnt", int'(digit_count), 0);
        cyc(0, 1, 12);
        idle(4);
        check("x_empty", int'(X), 0);
        check("xv_empty", int'(X_valid), 1);
        idle(1);
        keys('{0, 0, 4, 2});
        check("cnt_4", int'(digit_count), 4);
        cyc(0, 1, 12);
        idle(5);
        check("x_42", int'(X), 42);
        keys('{6});
        cyc(0, 1, 12);
        idle(1);
        cyc(0, 1, 3);
        check("drop_conv", int'(key_dropped), 1);
        idle(3);
        check("x_6", int'(X), 6);
        check("bcd_no3", int'(bcd), 0);
        keys('{7, 1});
        cyc(0, 1, 12);
        idle(2);
        cyc(1, 0, 0);
        check("abort_X", int'(X), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_bcd", int'(bcd), 0);
        idle(6);
        keys('{8});
        cyc(0, 1, 12);
        idle(5);
        check("x_8", int'(X), 8);
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 249) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
